// File: rtl/spo2_sequencer.sv
// SpO2 computation sequencer: gathers IR (led1) and RED (led2) channel
// results, launches the final SpO2 computation, supervises it with a
// timeout, range-checks and clamps the result, and presents it.
// Optional feature macro: SPO2_AVG_EN -- when defined, spo2_out is the
// 4-entry moving average of accepted results instead of the raw result.
module spo2_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MIN_SPO2       = 70,
  parameter int unsigned MAX_SPO2       = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        led1_dv,
  input  logic [23:0] led1_ac,
  input  logic [23:0] led1_dc,
  input  logic        led2_dv,
  input  logic [23:0] led2_ac,
  input  logic [23:0] led2_dc,
  output logic        comp_dv,
  output logic [23:0] comp_led1_ac,
  output logic [23:0] comp_led1_dc,
  output logic [23:0] comp_led2_ac,
  output logic [23:0] comp_led2_dc,
  input  logic        comp_done,
  input  logic [23:0] comp_spo2,
  output logic [23:0] spo2_out,
  output logic        spo2_valid,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_range,
  output logic        drop
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] MinVal = 24'(MIN_SPO2);
  localparam logic [23:0] MaxVal = 24'(MAX_SPO2);

  typedef enum logic [2:0] {
    S_COLLECT, S_LAUNCH, S_WAIT, S_CHECK, S_OUTPUT
  } state_e;

  state_e          state_q, state_d;
  logic            got1_q, got1_d, got2_q, got2_d;
  logic [23:0]     led1Ac_q, led1Ac_d, led1Dc_q, led1Dc_d;
  logic [23:0]     led2Ac_q, led2Ac_d, led2Dc_q, led2Dc_d;
  logic [23:0]     compA1_q, compA1_d, compD1_q, compD1_d;
  logic [23:0]     compA2_q, compA2_d, compD2_q, compD2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [23:0]     result_q, result_d;
  logic [23:0]     spo2_q, spo2_d;
  logic            errRange_q, errRange_d, errTimeout_q, errTimeout_d;
  logic            drop_q, drop_d;
  logic            accept;
  logic [23:0]     clamped;

  // Next-state logic: operand collection, launch decision, timeout supervision, result check
  always_comb begin
    state_d      = state_q;
    got1_d       = got1_q;
    got2_d       = got2_q;
    led1Ac_d     = led1Ac_q;
    led1Dc_d     = led1Dc_q;
    led2Ac_d     = led2Ac_q;
    led2Dc_d     = led2Dc_q;
    compA1_d     = compA1_q;
    compD1_d     = compD1_q;
    compA2_d     = compA2_q;
    compD2_d     = compD2_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    errRange_d   = 1'b0;
    errTimeout_d = 1'b0;
    accept       = 1'b0;
    clamped      = (result_q > MaxVal) ? MaxVal : result_q;
    drop_d       = (state_q != S_COLLECT) && (led1_dv || led2_dv);
    unique case (state_q)
      S_COLLECT: begin
        if (led1_dv) begin
          got1_d   = 1'b1;
          led1Ac_d = led1_ac;
          led1Dc_d = led1_dc;
        end
        if (led2_dv) begin
          got2_d   = 1'b1;
          led2Ac_d = led2_ac;
          led2Dc_d = led2_dc;
        end
        // Decision uses this cycle's strobes so launch follows the second operand by one cycle.
        if (got1_d && got2_d && enable) begin
          got1_d = 1'b0;
          got2_d = 1'b0;
          if (led1Dc_d == 24'd0 || led2Dc_d == 24'd0) begin
            errRange_d = 1'b1;
          end else begin
            state_d  = S_LAUNCH;
            compA1_d = led1Ac_d;
            compD1_d = led1Dc_d;
            compA2_d = led2Ac_d;
            compD2_d = led2Dc_d;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (comp_done) begin
          result_d = comp_spo2;
          state_d  = S_CHECK;
        end else if (cnt_q == CntLast) begin
          errTimeout_d = 1'b1;
          state_d      = S_COLLECT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_CHECK: begin
        if (result_q < MinVal) begin
          errRange_d = 1'b1;
          state_d    = S_COLLECT;
        end else begin
          accept  = 1'b1;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

`ifdef SPO2_AVG_EN
  logic [3:0][23:0] hist_q, hist_d;
  logic             primed_q, primed_d;
  logic [25:0]      sum;

  // Moving average: the first accepted result seeds every history slot
  always_comb begin
    hist_d   = hist_q;
    primed_d = primed_q;
    spo2_d   = spo2_q;
    sum      = '0;
    if (accept) begin
      if (!primed_q) begin
        hist_d   = {4{clamped}};
        primed_d = 1'b1;
      end else begin
        hist_d = {clamped, hist_q[3], hist_q[2], hist_q[1]};
      end
      sum    = 26'(hist_d[0]) + 26'(hist_d[1]) + 26'(hist_d[2]) + 26'(hist_d[3]);
      spo2_d = sum[25:2];
    end
  end

  // Averaging history registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      primed_q <= primed_d;
    end
  end
`else
  // Accepted result goes straight to the output register
  always_comb begin
    spo2_d = accept ? clamped : spo2_q;
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_COLLECT;
      got1_q       <= 1'b0;
      got2_q       <= 1'b0;
      led1Ac_q     <= '0;
      led1Dc_q     <= '0;
      led2Ac_q     <= '0;
      led2Dc_q     <= '0;
      compA1_q     <= '0;
      compD1_q     <= '0;
      compA2_q     <= '0;
      compD2_q     <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      spo2_q       <= '0;
      errRange_q   <= 1'b0;
      errTimeout_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      got1_q       <= got1_d;
      got2_q       <= got2_d;
      led1Ac_q     <= led1Ac_d;
      led1Dc_q     <= led1Dc_d;
      led2Ac_q     <= led2Ac_d;
      led2Dc_q     <= led2Dc_d;
      compA1_q     <= compA1_d;
      compD1_q     <= compD1_d;
      compA2_q     <= compA2_d;
      compD2_q     <= compD2_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      spo2_q       <= spo2_d;
      errRange_q   <= errRange_d;
      errTimeout_q <= errTimeout_d;
      drop_q       <= drop_d;
    end
  end

  assign comp_dv      = (state_q == S_LAUNCH);
  assign spo2_valid   = (state_q == S_OUTPUT);
  assign busy         = (state_q != S_COLLECT);
  assign comp_led1_ac = compA1_q;
  assign comp_led1_dc = compD1_q;
  assign comp_led2_ac = compA2_q;
  assign comp_led2_dc = compD2_q;
  assign spo2_out     = spo2_q;
  assign err_timeout  = errTimeout_q;
  assign err_range    = errRange_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_spo2_sequencer.sv
// Scoreboard bench for spo2_sequencer: stimulus pushes expected output
// events (cycle, pulse flags, busy, held operands and spo2_out) into a
// queue; a negedge monitor pops and compares whenever any pulse output fires.
module tb_spo2_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, enable;
  logic        led1_dv, led2_dv;
  logic [23:0] led1_ac, led1_dc, led2_ac, led2_dc;
  logic        comp_dv;
  logic [23:0] comp_led1_ac, comp_led1_dc, comp_led2_ac, comp_led2_dc;
  logic        comp_done;
  logic [23:0] comp_spo2, spo2_out;
  logic        spo2_valid, busy, err_timeout, err_range, drop;

  // Event flag encoding: {comp_dv, spo2_valid, err_timeout, err_range, drop}
  localparam logic [4:0] F_LAUNCH = 5'b10000;
  localparam logic [4:0] F_VALID  = 5'b01000;
  localparam logic [4:0] F_TMO    = 5'b00100;
  localparam logic [4:0] F_RANGE  = 5'b00010;
  localparam logic [4:0] F_DROP   = 5'b00001;

  typedef struct {
    int          cyc;
    logic [4:0]  flags;
    logic        busy;
    logic [23:0] out;
    logic [23:0] a1, d1, a2, d2;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  logic [4:0]  monF;
  int          cyc = 0;
  int          nCompared = 0;
  int          nMismatched = 0;
  logic [23:0] heldOut, mA1, mD1, mA2, mD2;
`ifdef SPO2_AVG_EN
  logic [23:0] hist[4];
  logic        primed;
`endif

  spo2_sequencer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .led1_dv(led1_dv), .led1_ac(led1_ac), .led1_dc(led1_dc),
    .led2_dv(led2_dv), .led2_ac(led2_ac), .led2_dc(led2_dc),
    .comp_dv(comp_dv), .comp_led1_ac(comp_led1_ac), .comp_led1_dc(comp_led1_dc),
    .comp_led2_ac(comp_led2_ac), .comp_led2_dc(comp_led2_dc),
    .comp_done(comp_done), .comp_spo2(comp_spo2),
    .spo2_out(spo2_out), .spo2_valid(spo2_valid), .busy(busy),
    .err_timeout(err_timeout), .err_range(err_range), .drop(drop)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter: cycle k is the interval after the k-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int c, input logic [4:0] f, input logic b);
    exp_t e;
    e.cyc = c; e.flags = f; e.busy = b; e.out = heldOut;
    e.a1 = mA1; e.d1 = mD1; e.a2 = mA2; e.d2 = mD2;
    expQ.push_back(e);
  endtask

  task automatic modelReset();
    heldOut = '0; mA1 = '0; mD1 = '0; mA2 = '0; mD2 = '0;
`ifdef SPO2_AVG_EN
    primed = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
`endif
  endtask

  task automatic modelAccept(input logic [23:0] r);
`ifdef SPO2_AVG_EN
    logic [25:0] s;
    if (!primed) begin
      for (int i = 0; i < 4; i++) hist[i] = r;
      primed = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) hist[i] = hist[i+1];
      hist[3] = r;
    end
    s = 26'(hist[0]) + 26'(hist[1]) + 26'(hist[2]) + 26'(hist[3]);
    heldOut = s[25:2];
`else
    heldOut = r;
`endif
  endtask

  // Expect a launch one cycle after the current (decision) cycle
  task automatic expLaunch(input logic [23:0] a1, d1, a2, d2);
    mA1 = a1; mD1 = d1; mA2 = a2; mD2 = d2;
    pushExp(cyc + 1, F_LAUNCH, 1'b1);
  endtask

  task automatic applyStimulus(input logic v1, input logic [23:0] a1, d1,
                               input logic v2, input logic [23:0] a2, d2);
    led1_dv = v1; led1_ac = a1; led1_dc = d1;
    led2_dv = v2; led2_ac = a2; led2_dc = d2;
    tick();
    led1_dv = 1'b0; led2_dv = 1'b0;
  endtask

  task automatic launchPair(input logic [23:0] a1, d1, a2, d2);
    expLaunch(a1, d1, a2, d2);
    applyStimulus(1'b1, a1, d1, 1'b1, a2, d2);
  endtask

  // Completion in WAIT; outcome appears two cycles later
  task automatic finishComp(input logic [23:0] val);
    if (val < 24'd70) begin
      pushExp(cyc + 2, F_RANGE, 1'b0);
    end else begin
      modelAccept((val > 24'd100) ? 24'd100 : val);
      pushExp(cyc + 2, F_VALID, 1'b1);
    end
    comp_done = 1'b1; comp_spo2 = val;
    tick();
    comp_done = 1'b0;
    repeat (4) tick();
  endtask

  // Monitor: pops one expectation per observed output pulse
  always @(negedge clk) begin
    monF = {comp_dv, spo2_valid, err_timeout, err_range, drop};
    if (monF != 5'b0) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_event: flags %b at cycle %0d, expected none", monF, cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("event_cycle", cyc, monE.cyc);
        checkOutput("event_flags", 32'(monF), 32'(monE.flags));
        checkOutput("busy", 32'(busy), 32'(monE.busy));
        checkOutput("spo2_out", 32'(spo2_out), 32'(monE.out));
        checkOutput("comp_led1_ac", 32'(comp_led1_ac), 32'(monE.a1));
        checkOutput("comp_led1_dc", 32'(comp_led1_dc), 32'(monE.d1));
        checkOutput("comp_led2_ac", 32'(comp_led2_ac), 32'(monE.a2));
        checkOutput("comp_led2_dc", 32'(comp_led2_dc), 32'(monE.d2));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    int c;
    reset_n = 1'b0; enable = 1'b1; comp_done = 1'b0; comp_spo2 = '0;
    led1_dv = 1'b0; led2_dv = 1'b0;
    led1_ac = '0; led1_dc = '0; led2_ac = '0; led2_dc = '0;
    modelReset();
    repeat (3) tick();
    checkOutput("reset_spo2_out", 32'(spo2_out), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_comp_dv", 32'(comp_dv), 0);
    checkOutput("reset_spo2_valid", 32'(spo2_valid), 0);
    checkOutput("reset_errors", 32'({err_timeout, err_range, drop}), 0);
    checkOutput("reset_comp_led1_ac", 32'(comp_led1_ac), 0);
    reset_n = 1'b1;
    tick();

    // Separate strobes, result 97
    applyStimulus(1'b1, 24'd20, 24'd1000, 1'b0, 24'd0, 24'd0);
    tick(); tick();
    expLaunch(24'd20, 24'd1000, 24'd30, 24'd1000);
    applyStimulus(1'b0, 24'd0, 24'd0, 1'b1, 24'd30, 24'd1000);
    repeat (5) tick();
    finishComp(24'd97);

    // Timeout: no completion for 64 WAIT cycles
    c = cyc;
    launchPair(24'd11, 24'd2000, 24'd22, 24'd2000);
    pushExp(c + 66, F_TMO, 1'b0);
    repeat (70) tick();

    // Clamp above ceiling
    launchPair(24'd40, 24'd3000, 24'd50, 24'd3000);
    repeat (3) tick();
    finishComp(24'd105);

    // Below floor: rejected, spo2_out held
    launchPair(24'd41, 24'd3100, 24'd51, 24'd3100);
    repeat (3) tick();
    finishComp(24'd60);

    // Zero DC: no launch
    pushExp(cyc + 1, F_RANGE, 1'b0);
    applyStimulus(1'b1, 24'd5, 24'd500, 1'b1, 24'd6, 24'd0);
    repeat (3) tick();

    // Strobe during WAIT is dropped, operands unchanged
    launchPair(24'd60, 24'd4000, 24'd70, 24'd4000);
    tick(); tick();
    pushExp(cyc + 1, F_DROP, 1'b1);
    applyStimulus(1'b1, 24'd99, 24'd99, 1'b0, 24'd0, 24'd0);
    tick();
    finishComp(24'd98);

    // Completion on the terminal-count cycle wins over timeout
    c = cyc;
    launchPair(24'd12, 24'd1200, 24'd13, 24'd1300);
    while (cyc < c + 65) tick();
    finishComp(24'd96);

    // Enable low holds operands; stray completion in COLLECT is ignored
    enable = 1'b0;
    applyStimulus(1'b1, 24'd7, 24'd700, 1'b1, 24'd8, 24'd800);
    repeat (2) tick();
    comp_done = 1'b1; comp_spo2 = 24'd99;
    tick();
    comp_done = 1'b0;
    repeat (2) tick();
    expLaunch(24'd7, 24'd700, 24'd8, 24'd800);
    enable = 1'b1;
    repeat (4) tick();
    finishComp(24'd92);

    // Reset mid-WAIT, then late completion is ignored
    launchPair(24'd1, 24'd100, 24'd2, 24'd100);
    repeat (3) tick();
    reset_n = 1'b0;
    modelReset();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    comp_done = 1'b1; comp_spo2 = 24'd99;
    tick();
    comp_done = 1'b0;
    repeat (5) tick();
    checkOutput("post_reset_spo2_out", 32'(spo2_out), 0);
    checkOutput("post_reset_busy", 32'(busy), 0);
    checkOutput("post_reset_comp_led2_dc", 32'(comp_led2_dc), 0);

    checkOutput("queue_drained", 32'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/spo2_sequencer.md
SPO2_SEQUENCER -- requirements
Module: spo2_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum cycles in WAIT for comp_done before abort.
REQ-002 Parameter: MIN_SPO2, 70, lowest accepted SpO2 result (integer percent).
REQ-003 Parameter: MAX_SPO2, 100, clamp ceiling for SpO2 result.
REQ-004 Ports: clk input 1, rising-edge clock; reset_n input 1, synchronous active-low reset.
REQ-005 Ports: enable input 1, permits launching new computations.
REQ-006 Ports: led1_dv input 1, led1_ac input 24, led1_dc input 24 -- IR channel result strobe and values.
REQ-007 Ports: led2_dv input 1, led2_ac input 24, led2_dc input 24 -- RED channel result strobe and values.
REQ-008 Ports: comp_dv output 1, comp_led1_ac/comp_led1_dc/comp_led2_ac/comp_led2_dc output 24 each -- launch pulse and operands to final computation.
REQ-009 Ports: comp_done input 1, comp_spo2 input 24 -- completion strobe and integer result from final computation.
REQ-010 Ports: spo2_out output 24, spo2_valid output 1, busy output 1, err_timeout output 1, err_range output 1, drop output 1.

Function
REQ-011 States SHALL be COLLECT, LAUNCH, WAIT, CHECK, OUTPUT; busy = 1 in every state except COLLECT.
REQ-012 COLLECT: ledN_dv latches ledN_ac/dc into operand registers and sets flag gotN; a repeat strobe overwrites; simultaneous led1_dv and led2_dv both latch.
REQ-013 COLLECT -> LAUNCH when got1 & got2 & enable at a clock edge; with enable = 0 flags and operands hold.
REQ-014 If either latched DC is zero at the launch decision, no launch: err_range pulses 1 cycle, flags clear, stay COLLECT.
REQ-015 LAUNCH: comp_dv = 1 for exactly one cycle; comp_led* outputs hold the latched operands from LAUNCH until the next LAUNCH; next state WAIT, timeout counter cleared.
REQ-016 WAIT: counter increments each cycle; comp_done = 1 captures comp_spo2, goes CHECK; counter reaching TIMEOUT_CYCLES without comp_done pulses err_timeout, clears flags, goes COLLECT; comp_done on the terminal-count cycle wins over timeout.
REQ-017 CHECK: result < MIN_SPO2 -> err_range pulse, no spo2_valid, go COLLECT; result > MAX_SPO2 -> clamped to MAX_SPO2 (no error); else unchanged; accepted -> OUTPUT.
REQ-018 OUTPUT: spo2_out updated, spo2_valid = 1 for one cycle, flags cleared, go COLLECT.
REQ-019 Latency: comp_dv in cycle N+1 after second operand latched in cycle N; spo2_valid in cycle M+2 after comp_done in cycle M.
REQ-020 ledN_dv outside COLLECT is ignored and pulses drop for 1 cycle; comp_done outside WAIT is ignored.
REQ-021 spo2_out holds its value between spo2_valid pulses; error pulses do not alter spo2_out.

Reset
REQ-022 reset_n = 0 at a clock edge: state COLLECT, flags, counter, operands cleared; all outputs 0.
REQ-023 Reset mid-WAIT aborts silently; a comp_done arriving after reset is ignored (REQ-020).

Configuration
REQ-024 Macro SPO2_AVG_EN defined: spo2_out = 4-entry moving average of accepted results, sum >> 2 truncated; first accepted result after reset fills all 4 entries; latency unchanged.
REQ-025 Macro SPO2_AVG_EN undefined: spo2_out = the accepted (clamped) result directly; no averaging storage.

Verification
REQ-026 led1 (ac 20, dc 1000) cycle 5, led2 (ac 30, dc 1000) cycle 8, enable 1 -> comp_dv cycle 9 with those operands; comp_done cycle 15, comp_spo2 97 -> spo2_valid cycle 17, spo2_out 97.
REQ-027 Launch, no comp_done for 64 cycles -> err_timeout one-cycle pulse, busy 0, spo2_valid never asserted; next valid pair launches normally.
REQ-028 comp_spo2 = 105 -> spo2_out 100, no error; comp_spo2 = 60 -> err_range pulse, spo2_out unchanged, no spo2_valid.
REQ-029 led2_dc = 0 with led1 valid -> err_range pulse, no comp_dv; led1_dv during WAIT -> drop pulse, operands unchanged.
REQ-030 SPO2_AVG_EN defined: accepted results 96, 96, 100, 92, 100 -> spo2_out 96, 96, 97, 96, 97.
